mul_seq: RTL and testbench

- Sequential shift-add unsigned multiplier; upstream producer for the bit-serial square-root stage.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product.
- Default WIDTH=4 yields an 8-bit product, which connects directly to the root stage's 8-bit radicand input, with y_ready driving its input strobe.
- One multi-cycle FSM, one operation in flight, no pipelining.

---
 rtl/mul_seq.sv | 132 +++++++++++++
 tb/tb_mul_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add unsigned multiplier, one operation in flight.
//
// Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product by testing
// one multiplier bit per iteration (test / optional add / shift). With the
// default WIDTH=4 the 8-bit product feeds a bit-serial square-root stage
// directly, and y_ready serves as that stage's input strobe.
//
// Optional build macro: MUL_SEQ_EARLY_EXIT_EN
//   When defined, an operation also finishes as soon as the remaining
//   multiplier bits are all zero. The result is unchanged; only the
//   latency is shorter.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   a_in      multiplicand, sampled when a start is accepted
//   b_in      multiplier, sampled when a start is accepted
//   ab_ready  start strobe, honoured only when idle
//   y_out     product, held until the next completion or reset
//   y_ready   high while y_out holds a valid result
//   busy      high whenever an operation is in progress
module mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               ab_ready,
    output logic [2*WIDTH-1:0] y_out,
    output logic               y_ready,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle
        S1 = 2'd1,  // test current multiplier bit / finish
        S2 = 2'd2,  // add shifted multiplicand
        S3 = 2'd3   // shift operands, count down
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]    a_r;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;

    logic load, add, shift, done, finish;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // No remaining multiplier bits set means no further adds can occur.
    assign finish = (cnt == '0) || (b_r == '0);
`else
    assign finish = (cnt == '0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S0;
        else     state <= state_next;
    end

    // Next state and datapath controls
    always_comb begin
        state_next = state;
        load       = 1'b0;
        add        = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        case (state)
            S0: if (ab_ready) begin
                    load       = 1'b1;
                    state_next = S1;
                end
            S1: if (finish) begin
                    done       = 1'b1;
                    state_next = S0;
                end else if (b_r[0]) begin
                    state_next = S2;
                end else begin
                    state_next = S3;
                end
            S2: begin
                    add        = 1'b1;
                    state_next = S3;
                end
            S3: begin
                    shift      = 1'b1;
                    state_next = S1;
                end
            default: state_next = S0;
        endcase
    end

    // Published result. A reset mid-operation simply never reaches 'done',
    // so no partial accumulator value escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_out   <= '0;
            y_ready <= 1'b0;
        end else if (load) begin
            y_ready <= 1'b0;
        end else if (done) begin
            y_out   <= acc;
            y_ready <= 1'b1;
        end
    end

    // Datapath: contents are don't-care while idle, so no reset.
    // The accumulator cannot overflow since the full product fits in PW bits.
    always_ff @(posedge clk) begin
        if (load) begin
            a_r <= {{WIDTH{1'b0}}, a_in};
            b_r <= b_in;
            acc <= '0;
            cnt <= CW'(WIDTH);
        end else if (add) begin
            acc <= acc + a_r;
        end else if (shift) begin
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (state != S0);

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver pushes the expected product and
// the expected completion edge for every accepted start; an independent
// monitor pops and compares on each rising y_ready.
module tb_mul_seq;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          ab_ready = 1'b0;
    logic [PW-1:0] y_out;
    logic          y_ready;
    logic          busy;

    mul_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .ab_ready (ab_ready),
        .y_out    (y_out),
        .y_ready  (y_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint prod;
        int     done_cyc;
    } exp_t;

    exp_t   q[$];
    int     n_chk  = 0;
    int     n_pass = 0;
    longint last_prod = 0;
    logic   prev_yr = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Edges from the accepting edge up to and including the completion edge.
    function automatic int lat(input int b);
        int pop = 0;
        int k   = 0;
        for (int i = 0; i < W; i++) begin
            if ((b >> i) & 1) begin
                pop++;
                k = i + 1;
            end
        end
`ifdef MUL_SEQ_EARLY_EXIT_EN
        return 2 + 2 * k + pop;
`else
        if (k < 0) return 0;
        return 2 + 2 * W + pop;
`endif
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && y_ready && !prev_yr) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                check("product", y_out, e.prod);
                check("done_edge", cyc, e.done_cyc);
                check("busy_at_done", busy, 0);
                last_prod = e.prod;
            end
        end
        prev_yr = y_ready;
    end

    task automatic start(input int a, input int b);
        @(negedge clk);
        a_in = W'(a); b_in = W'(b); ab_ready = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{longint'(a * b), cyc + lat(b) - 1});
        check("busy_after_start", busy, 1);
        check("yready_cleared", y_ready, 0);
        @(negedge clk);
        ab_ready = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        // Reset and idle
        a_in = W'($urandom); b_in = W'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_y_out", y_out, 0);
        check("rst_y_ready", y_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_y_out", y_out, 0);
        check("idle_y_ready", y_ready, 0);
        check("idle_busy", busy, 0);

        // Directed cases
        start(3, 5);   wait_idle();
        repeat (3) @(negedge clk);
        check("hold_y_out", y_out, last_prod);
        check("hold_y_ready", y_ready, 1);
        start(15, 15); wait_idle();
        start(0, 9);   wait_idle();
        start(7, 0);   wait_idle();

        // Strobe while busy is ignored
        start(2, 6);
        repeat (2) @(negedge clk);
        a_in = 4'd9; b_in = 4'd9; ab_ready = 1'b1;
        @(negedge clk);
        ab_ready = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        check("no_second_op_busy", busy, 0);
        check("no_second_op_y", y_out, 12);

        // Mid-operation reset, then a clean operation
        start(10, 10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        check("midrst_y_out", y_out, 0);
        check("midrst_y_ready", y_ready, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        start(4, 4); wait_idle();

        // Reset wins over a simultaneous strobe
        @(negedge clk);
        rst = 1'b1; ab_ready = 1'b1; a_in = 4'd5; b_in = 4'd5;
        @(negedge clk);
        check("rst_wins_busy", busy, 0);
        check("rst_wins_y_ready", y_ready, 0);
        rst = 1'b0; ab_ready = 1'b0;
        @(negedge clk);

        // Held strobe: back-to-back 9*9, one-cycle y_ready pulses
        begin
            int l;
            l = lat(9);
            @(negedge clk);
            a_in = 4'd9; b_in = 4'd9; ab_ready = 1'b1;
            @(posedge clk); #1;
            q.push_back('{81, cyc + l - 1});
            for (int i = 1; i < 3; i++) begin
                repeat (l) @(posedge clk);
                #1;
                check("held_pulse_cleared", y_ready, 0);
                check("held_busy", busy, 1);
                q.push_back('{81, cyc + l - 1});
            end
            repeat (l - 1) @(posedge clk);
            @(negedge clk);
            ab_ready = 1'b0;
            wait_idle();
        end

        // Randomized operations with random idle gaps
        for (int n = 0; n < 40; n++) begin
            start(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
